// File: rtl/ros2_eth_rx_adapter.sv
// ros2_eth_rx_adapter
// Re-serializes a parsed IPv4 header plus an 8-bit AXI-Stream payload into a
// flat byte stream for the ROS2 core input FIFO. Header bytes are emitted in
// IPv4 wire order, followed by exactly (total length - 20) payload bytes.
// Short payloads are zero-padded, excess payload is drained without writes,
// and a one-cycle o_frame_err pulse marks every repaired or bad frame.
module ros2_eth_rx_adapter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   // parsed IPv4 header
   input  logic        i_rx_hdr_valid,
   output logic        o_rx_hdr_ready,
   input  logic [5:0]  i_rx_ip_dscp,
   input  logic [1:0]  i_rx_ip_ecn,
   input  logic [15:0] i_rx_ip_length,
   input  logic [15:0] i_rx_ip_identification,
   input  logic [2:0]  i_rx_ip_flags,
   input  logic [12:0] i_rx_ip_fragment_offset,
   input  logic [7:0]  i_rx_ip_ttl,
   input  logic [7:0]  i_rx_ip_protocol,
   input  logic [15:0] i_rx_ip_header_checksum,
   input  logic [31:0] i_rx_ip_source_ip,
   input  logic [31:0] i_rx_ip_dest_ip,
   // payload stream
   input  logic        i_rx_payload_tvalid,
   output logic        o_rx_payload_tready,
   input  logic [7:0]  i_rx_payload_tdata,
   input  logic        i_rx_payload_tlast,
   input  logic        i_rx_payload_tuser,
   // FIFO write side
   output logic [7:0]  o_dout_data,
   output logic        o_dout_wr_en,
   input  logic        i_dout_full_n,
   output logic        o_frame_err
);

   typedef enum logic [2:0] {
      IDLE,
      WR_HDR,
      WR_PAYLOAD,
      PAD,
      DROP
   } state_t;

   localparam logic [15:0] HDR_BYTES = 16'd20;
   localparam logic [4:0]  LAST_HDR_IDX = 5'd19;

   state_t        state_reg;
   logic [159:0]  hdr_reg;        // whole header, byte 0 in the top bits
   logic [15:0]   len_reg;        // payload bytes still owed to the FIFO in total
   logic [15:0]   cnt_reg;        // payload bytes written (or padded) so far
   logic [4:0]    k_reg;          // header byte index 0..19
   logic          drop_err_reg;   // DROP was entered for an error condition
   logic          frame_err_reg;

   logic [7:0]    hdr_byte [0:19];
   logic [15:0]   cnt_inc;
   logic          active;
   logic          pay_accept;
   logic          last_payload;

   // Reset and disable both force every handshake/strobe low immediately.
   assign active       = i_enable & ~i_rst;
   assign cnt_inc      = cnt_reg + 16'd1;
   assign pay_accept   = i_rx_payload_tvalid & i_dout_full_n;
   assign last_payload = (cnt_inc == len_reg);
   assign o_frame_err  = frame_err_reg;

   // Slice the latched header into its 20 wire-order bytes.
   genvar gi;
   generate
      for (gi = 0; gi < 20; gi++) begin : g_hdr_byte
         assign hdr_byte[gi] = hdr_reg[159 - 8*gi -: 8];
      end
   endgenerate

   // Handshakes and FIFO strobe are combinational so that payload is a
   // zero-latency pass-through and FIFO back-pressure acts in the same cycle.
   always_comb begin
      o_rx_hdr_ready      = 1'b0;
      o_rx_payload_tready = 1'b0;
      o_dout_wr_en        = 1'b0;
      o_dout_data         = 8'h00;
      if (active) begin
         case (state_reg)
            IDLE: begin
               o_rx_hdr_ready = 1'b1;
            end
            WR_HDR: begin
               o_dout_wr_en = i_dout_full_n;
               o_dout_data  = hdr_byte[k_reg];
            end
            WR_PAYLOAD: begin
               o_rx_payload_tready = i_dout_full_n;
               o_dout_wr_en        = pay_accept;
               o_dout_data         = i_rx_payload_tdata;
            end
            PAD: begin
               o_dout_wr_en = i_dout_full_n;
               o_dout_data  = 8'h00;
            end
            DROP: begin
               o_rx_payload_tready = 1'b1;
            end
            default: begin
               o_dout_wr_en = 1'b0;
            end
         endcase
      end
   end

   // Frame sequencing: header latch, header emission, payload copy, padding
   // of short payloads and draining of excess or malformed payloads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= IDLE;
         hdr_reg       <= '0;
         len_reg       <= '0;
         cnt_reg       <= '0;
         k_reg         <= '0;
         drop_err_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else if (!i_enable) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         cnt_reg       <= '0;
         k_reg         <= '0;
         drop_err_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         frame_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (i_rx_hdr_valid) begin
                  hdr_reg <= {8'h45,
                              i_rx_ip_dscp, i_rx_ip_ecn,
                              i_rx_ip_length,
                              i_rx_ip_identification,
                              i_rx_ip_flags, i_rx_ip_fragment_offset,
                              i_rx_ip_ttl,
                              i_rx_ip_protocol,
                              i_rx_ip_header_checksum,
                              i_rx_ip_source_ip,
                              i_rx_ip_dest_ip};
                  cnt_reg <= '0;
                  k_reg   <= '0;
                  if (i_rx_ip_length < HDR_BYTES) begin
                     // Malformed length: emit nothing, swallow the payload.
                     len_reg      <= '0;
                     drop_err_reg <= 1'b1;
                     state_reg    <= DROP;
                  end else begin
                     len_reg      <= i_rx_ip_length - HDR_BYTES;
                     drop_err_reg <= 1'b0;
                     state_reg    <= WR_HDR;
                  end
               end
            end
            WR_HDR: begin
               if (i_dout_full_n) begin
                  if (k_reg == LAST_HDR_IDX) begin
                     k_reg <= '0;
                     if (len_reg == 16'd0) begin
                        // Header-only packet: its single payload beat is
                        // discarded silently.
                        drop_err_reg <= 1'b0;
                        state_reg    <= DROP;
                     end else begin
                        state_reg <= WR_PAYLOAD;
                     end
                  end else begin
                     k_reg <= k_reg + 5'd1;
                  end
               end
            end
            WR_PAYLOAD: begin
               if (pay_accept) begin
                  cnt_reg <= cnt_inc;
                  if (last_payload) begin
                     if (i_rx_payload_tlast) begin
                        frame_err_reg <= i_rx_payload_tuser;
                        state_reg     <= IDLE;
                     end else begin
                        // More input than the header promised.
                        drop_err_reg <= 1'b1;
                        state_reg    <= DROP;
                     end
                  end else if (i_rx_payload_tlast) begin
                     // Input ended early: fill the rest with zeros.
                     frame_err_reg <= 1'b1;
                     state_reg     <= PAD;
                  end
               end
            end
            PAD: begin
               if (i_dout_full_n) begin
                  cnt_reg <= cnt_inc;
                  if (last_payload) begin
                     state_reg <= IDLE;
                  end
               end
            end
            DROP: begin
               if (i_rx_payload_tvalid && i_rx_payload_tlast) begin
                  frame_err_reg <= drop_err_reg;
                  drop_err_reg  <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ros2_eth_rx_adapter.sv
// tb_ros2_eth_rx_adapter
// Directed bench: nominal, back-pressure, short/long payload, malformed and
// header-only lengths, bad-frame flag, enable abort and mid-frame reset.
module tb_ros2_eth_rx_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [5:0]  ip_dscp;
   logic [1:0]  ip_ecn;
   logic [15:0] ip_length;
   logic [15:0] ip_id;
   logic [2:0]  ip_flags;
   logic [12:0] ip_frag;
   logic [7:0]  ip_ttl;
   logic [7:0]  ip_proto;
   logic [15:0] ip_csum;
   logic [31:0] ip_src;
   logic [31:0] ip_dst;
   logic        tvalid;
   logic        tready;
   logic [7:0]  tdata;
   logic        tlast;
   logic        tuser;
   logic [7:0]  dout_data;
   logic        dout_wr_en;
   logic        full_n;
   logic        frame_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   int          err_pulses;
   int          bp_viol;
   // Hand-computed header bytes 4..19 for the fixed field values below:
   // id 1234, {flags 010, frag 0005} = 4005, ttl 40, proto 11, csum BEEF,
   // src 0A000001, dst 0A000002. Byte 1 {dscp 2E, ecn 1} = B9.
   logic [127:0] hdr_tail;

   always #5 clk = ~clk;

   ros2_eth_rx_adapter dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_enable                (enable),
      .i_rx_hdr_valid          (hdr_valid),
      .o_rx_hdr_ready          (hdr_ready),
      .i_rx_ip_dscp            (ip_dscp),
      .i_rx_ip_ecn             (ip_ecn),
      .i_rx_ip_length          (ip_length),
      .i_rx_ip_identification  (ip_id),
      .i_rx_ip_flags           (ip_flags),
      .i_rx_ip_fragment_offset (ip_frag),
      .i_rx_ip_ttl             (ip_ttl),
      .i_rx_ip_protocol        (ip_proto),
      .i_rx_ip_header_checksum (ip_csum),
      .i_rx_ip_source_ip       (ip_src),
      .i_rx_ip_dest_ip         (ip_dst),
      .i_rx_payload_tvalid     (tvalid),
      .o_rx_payload_tready     (tready),
      .i_rx_payload_tdata      (tdata),
      .i_rx_payload_tlast      (tlast),
      .i_rx_payload_tuser      (tuser),
      .o_dout_data             (dout_data),
      .o_dout_wr_en            (dout_wr_en),
      .i_dout_full_n           (full_n),
      .o_frame_err             (frame_err)
   );

   // Single comparison point: counts and reports.
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected FIFO byte stream for a frame of the given length and payload size.
   task automatic build_exp(input logic [15:0] length, input int npay);
      logic [159:0] hb;
      int plen;
      exp_q.delete();
      if (length < 16'd20) return;
      hb = {8'h45, 8'hB9, length, hdr_tail};
      for (int i = 0; i < 20; i++) exp_q.push_back(hb[159 - 8*i -: 8]);
      plen = int'(length) - 20;
      for (int i = 0; i < plen; i++) exp_q.push_back((i < npay) ? 8'(i + 1) : 8'h00);
   endtask

   // Drive one header plus payload 01..npay; stops on completion or after
   // abort_at FIFO writes (abort_at = 0 runs to completion).
   task automatic run_frame(input logic [15:0] length, input int npay, input bit bad,
                            input bit bp, input bit gaps, input int abort_at);
      int  pidx = 0;
      int  cyc = 0;
      bit  hdr_done = 1'b0;
      bit  done = 1'b0;
      got_q.delete();
      err_pulses = 0;
      bp_viol    = 0;
      ip_length  = length;
      hdr_valid  = 1'b1;
      full_n     = 1'b1;
      while (!done && cyc < 600) begin
         tvalid = (pidx < npay) && (!gaps || $urandom_range(0, 2) != 0);
         tdata  = 8'(pidx + 1);
         tlast  = (pidx == npay - 1);
         tuser  = bad && (pidx == npay - 1);
         @(negedge clk);
         if (dout_wr_en) got_q.push_back(dout_data);
         if (frame_err) err_pulses++;
         if (tready && !full_n) bp_viol++;
         if (hdr_done && pidx == npay && hdr_ready) done = 1'b1;
         if (hdr_valid && hdr_ready) hdr_done = 1'b1;
         if (tvalid && tready) pidx++;
         if (abort_at > 0 && got_q.size() == abort_at) done = 1'b1;
         @(posedge clk);
         #1;
         if (hdr_done) hdr_valid = 1'b0;
         if (bp) full_n = ~full_n;
         cyc++;
      end
      if (!done) check_val("timeout", cyc, 0);
      hdr_valid = 1'b0;
      tvalid    = 1'b0;
      tlast     = 1'b0;
      tuser     = 1'b0;
      full_n    = 1'b1;
   endtask

   // Compare the captured stream against the model and check pulses.
   task automatic check_frame(input string name, input int exp_err);
      int n;
      check_val({name, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_val($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
      check_val({name, "_err"}, err_pulses, exp_err);
      check_val({name, "_tready_bp"}, bp_viol, 0);
      $display("frame %s: %0d bytes written, %0d error pulses", name, got_q.size(), err_pulses);
   endtask

   initial begin
      hdr_tail  = 128'h1234_4005_4011_BEEF_0A00_0001_0A00_0002;
      rst       = 1'b1;
      enable    = 1'b1;
      hdr_valid = 1'b0;
      ip_dscp   = 6'h2E;
      ip_ecn    = 2'b01;
      ip_length = 16'h0000;
      ip_id     = 16'h1234;
      ip_flags  = 3'b010;
      ip_frag   = 13'h0005;
      ip_ttl    = 8'h40;
      ip_proto  = 8'h11;
      ip_csum   = 16'hBEEF;
      ip_src    = 32'h0A00_0001;
      ip_dst    = 32'h0A00_0002;
      tvalid    = 1'b0;
      tdata     = 8'h00;
      tlast     = 1'b0;
      tuser     = 1'b0;
      full_n    = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_hdr_ready", hdr_ready, 0);
      check_val("rst_tready", tready, 0);
      check_val("rst_wr_en", dout_wr_en, 0);
      check_val("rst_data", dout_data, 0);
      check_val("rst_frame_err", frame_err, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("idle_hdr_ready", hdr_ready, 1);
      @(posedge clk);
      #1;

      build_exp(16'h001C, 8);
      run_frame(16'h001C, 8, 1'b0, 1'b0, 1'b0, 0);
      check_frame("nominal", 0);

      build_exp(16'h001C, 8);
      run_frame(16'h001C, 8, 1'b0, 1'b1, 1'b1, 0);
      check_frame("backpressure", 0);

      build_exp(16'h001C, 5);
      run_frame(16'h001C, 5, 1'b0, 1'b0, 1'b0, 0);
      check_frame("short", 1);

      build_exp(16'h0018, 10);
      run_frame(16'h0018, 10, 1'b0, 1'b0, 1'b1, 0);
      check_frame("long", 1);

      build_exp(16'h0010, 4);
      run_frame(16'h0010, 4, 1'b0, 1'b0, 1'b0, 0);
      check_frame("malformed", 1);

      build_exp(16'h0014, 1);
      run_frame(16'h0014, 1, 1'b0, 1'b0, 1'b0, 0);
      check_frame("hdr_only", 0);

      build_exp(16'h001C, 8);
      run_frame(16'h001C, 8, 1'b1, 1'b1, 1'b0, 0);
      check_frame("bad_tuser", 1);

      // Abort after 10 header bytes
      run_frame(16'h001C, 8, 1'b0, 1'b0, 1'b0, 10);
      check_val("abort_written", got_q.size(), 10);
      enable = 1'b0;
      @(negedge clk);
      check_val("abort_wr_en", dout_wr_en, 0);
      check_val("abort_hdr_ready", hdr_ready, 0);
      check_val("abort_tready", tready, 0);
      @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      check_val("abort_idle", hdr_ready, 1);
      @(posedge clk);
      #1;
      build_exp(16'h001C, 8);
      run_frame(16'h001C, 8, 1'b0, 1'b0, 1'b0, 0);
      check_frame("after_abort", 0);

      // Reset during payload
      run_frame(16'h001C, 8, 1'b0, 1'b0, 1'b0, 23);
      rst    = 1'b1;
      tvalid = 1'b1;
      tdata  = 8'h55;
      @(posedge clk);
      @(negedge clk);
      check_val("midrst_hdr_ready", hdr_ready, 0);
      check_val("midrst_tready", tready, 0);
      check_val("midrst_wr_en", dout_wr_en, 0);
      check_val("midrst_data", dout_data, 0);
      check_val("midrst_frame_err", frame_err, 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      tvalid = 1'b0;
      @(posedge clk);
      #1;
      build_exp(16'h001C, 8);
      run_frame(16'h001C, 8, 1'b0, 1'b0, 1'b0, 0);
      check_frame("after_reset", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
